// File: rtl/stack_pkg.sv
// Shared op encoding for the parameterised stack.
package stack_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_PUSH    = 2'b00;
  localparam op_t OP_POP     = 2'b01;
  localparam op_t OP_REPLACE = 2'b10;
  localparam op_t OP_NOP     = 2'b11;

endpackage

// File: rtl/stack_ptr.sv
// Saturating entry counter for param_stack; empty/full decode straight off the count register.
module stack_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inc,
  input  logic                         dec,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && count_q != CW'(DEPTH)) begin
      count_d = count_q + CW'(1);
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/param_stack.sv
// LIFO stack with registered top-of-stack and one-cycle err pulse on overflow/underflow.
// Define PARAM_STACK_STICKY_ERR_EN to add ovf_sticky/unf_sticky outputs held until rst.
module param_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         op_valid,
  input  logic [1:0]                   op,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             top_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         err
`ifdef PARAM_STACK_STICKY_ERR_EN
  ,
  output logic                         ovf_sticky,
  output logic                         unf_sticky
`endif
);

  op_t op_i;
  logic do_push, do_pop, do_repl, ovf, unf;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] top_data_q, top_data_d;
  logic             err_q, err_d;

  assign op_i = op;

  // REPLACE on an empty stack is treated as a PUSH; on a full one it never overflows.
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_repl = 1'b0;
    ovf     = 1'b0;
    unf     = 1'b0;
    if (op_valid) begin
      case (op_i)
        OP_PUSH:    if (full)  ovf = 1'b1; else do_push = 1'b1;
        OP_POP:     if (empty) unf = 1'b1; else do_pop  = 1'b1;
        OP_REPLACE: if (empty) do_push = 1'b1; else do_repl = 1'b1;
        default:    ;
      endcase
    end
  end

  stack_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (do_push),
    .dec   (do_pop),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    mem_d      = mem_q;
    top_data_d = top_data_q;
    err_d      = ovf | unf;
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && i == int'(count))     mem_d[i] = din;
      if (do_repl && i == int'(count) - 1) mem_d[i] = din;
      if (do_pop  && i == int'(count) - 1) mem_d[i] = '0;
    end
    if (do_push || do_repl) begin
      top_data_d = din;
    end else if (do_pop) begin
      // Entry below the popped one becomes the new top; none left means 0.
      top_data_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(count) - 2) top_data_d = mem_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      top_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      top_data_q <= top_data_d;
      err_q      <= err_d;
    end
  end

  assign top_data = top_data_q;
  assign err      = err_q;

`ifdef PARAM_STACK_STICKY_ERR_EN
  logic ovf_sticky_q, ovf_sticky_d;
  logic unf_sticky_q, unf_sticky_d;

  always_comb begin
    ovf_sticky_d = ovf_sticky_q | ovf;
    unf_sticky_d = unf_sticky_q | unf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky_q <= 1'b0;
      unf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
      unf_sticky_q <= unf_sticky_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
  assign unf_sticky = unf_sticky_q;
`endif

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack: queue-based reference model plus directed literal checks.
module tb_param_stack;
  import stack_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             op_valid = 1'b0;
  logic [1:0]       op = OP_NOP;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] top_data;
  logic [CW-1:0]    count;
  logic             empty, full, err;
`ifdef PARAM_STACK_STICKY_ERR_EN
  logic             ovf_sticky, unf_sticky;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  int model[$];
  bit m_err = 1'b0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  always #5 clk = ~clk;

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .din      (din),
    .top_data (top_data),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .err      (err)
`ifdef PARAM_STACK_STICKY_ERR_EN
    ,
    .ovf_sticky (ovf_sticky),
    .unf_sticky (unf_sticky)
`endif
  );

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int modelTop();
    return (model.size() == 0) ? 0 : model[model.size()-1];
  endfunction

  task automatic modelStep(input bit r, input bit v, input logic [1:0] o, input logic [WIDTH-1:0] d);
    m_err = 1'b0;
    if (r) begin
      model.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (v) begin
      case (o)
        OP_PUSH:
          if (model.size() == DEPTH) begin m_err = 1'b1; m_ovf = 1'b1; end
          else model.push_back(int'(d));
        OP_POP:
          if (model.size() == 0) begin m_err = 1'b1; m_unf = 1'b1; end
          else void'(model.pop_back());
        OP_REPLACE:
          if (model.size() == 0) model.push_back(int'(d));
          else model[model.size()-1] = int'(d);
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [1:0] o, input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst      = r;
    op_valid = v;
    op       = o;
    din      = d;
    @(posedge clk);
    modelStep(r, v, o, d);
    chk_en = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input int exp_count, input int exp_top, input bit exp_err);
    #1;
    checkVal({tag, "_count"}, 32'(count), exp_count);
    checkVal({tag, "_top"},   32'(top_data), exp_top);
    checkVal({tag, "_err"},   32'(err), 32'(exp_err));
  endtask

  // Every cycle after the first reset, the DUT must match the reference model.
  always @(negedge clk) begin
    if (chk_en) begin
      checkVal("cyc_count", 32'(count), model.size());
      checkVal("cyc_top",   32'(top_data), modelTop());
      checkVal("cyc_empty", 32'(empty), 32'(model.size() == 0));
      checkVal("cyc_full",  32'(full),  32'(model.size() == DEPTH));
      checkVal("cyc_err",   32'(err),   32'(m_err));
`ifdef PARAM_STACK_STICKY_ERR_EN
      checkVal("cyc_ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
      checkVal("cyc_unf_sticky", 32'(unf_sticky), 32'(m_unf));
`endif
    end
  end

  initial begin
    logic [WIDTH-1:0] pushes [4];
    logic [WIDTH-1:0] pops   [4];
    pushes = '{4'h3, 4'h5, 4'h9, 4'hC};
    pops   = '{4'h9, 4'h5, 4'h3, 4'h0};

    applyStimulus(1'b1, 1'b0, OP_NOP, 4'h0);
    applyStimulus(1'b1, 1'b0, OP_NOP, 4'h0);
    checkOutput("reset", 0, 0, 1'b0);
    checkVal("reset_empty", 32'(empty), 1);
    checkVal("reset_full",  32'(full),  0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, OP_PUSH, pushes[i]);
      checkOutput("push", i + 1, int'(pushes[i]), 1'b0);
    end
    checkVal("push_full", 32'(full), 1);

    applyStimulus(1'b0, 1'b1, OP_PUSH, 4'h7);
    checkOutput("overflow", 4, 'hC, 1'b1);
    applyStimulus(1'b0, 1'b1, OP_NOP, 4'h7);
    checkOutput("ovf_pulse_end", 4, 'hC, 1'b0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, OP_POP, 4'h0);
      checkOutput("pop", 3 - i, int'(pops[i]), 1'b0);
    end
    checkVal("pop_empty", 32'(empty), 1);
    applyStimulus(1'b0, 1'b1, OP_POP, 4'h0);
    checkOutput("underflow", 0, 0, 1'b1);

    applyStimulus(1'b0, 1'b1, OP_REPLACE, 4'hA);
    checkOutput("repl_empty", 1, 'hA, 1'b0);
    applyStimulus(1'b0, 1'b1, OP_REPLACE, 4'h6);
    checkOutput("repl", 1, 'h6, 1'b0);

    applyStimulus(1'b0, 1'b1, OP_PUSH, 4'h2);
    checkOutput("pre_rst", 2, 'h2, 1'b0);
    applyStimulus(1'b1, 1'b1, OP_PUSH, 4'hF);
    checkOutput("rst_prio", 0, 0, 1'b0);
    checkVal("rst_prio_empty", 32'(empty), 1);
    applyStimulus(1'b0, 1'b1, OP_PUSH, 4'h1);
    checkOutput("post_rst", 1, 'h1, 1'b0);

    applyStimulus(1'b0, 1'b1, OP_PUSH, 4'h2);
    applyStimulus(1'b0, 1'b1, OP_PUSH, 4'h3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, OP_POP, 4'h0);
      checkOutput("hold", 3, 'h3, 1'b0);
    end

    applyStimulus(1'b0, 1'b1, OP_PUSH, 4'h4);
    applyStimulus(1'b0, 1'b1, OP_REPLACE, 4'hE);
    checkOutput("repl_full", 4, 'hE, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 99) < 2,
                    $urandom_range(0, 99) < 85,
                    2'($urandom_range(0, 3)),
                    WIDTH'($urandom));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
